// File: rtl/rx_frame_fifo_pkg.sv
// Shared types and constants for the receive store-and-forward frame buffer.
// A buffer entry is one AXIS beat packed as {last, vldb, data}.
package rx_frame_fifo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned VLDB_W = 2;
    localparam int unsigned WORD_W = 35;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned DATA_MSB = 31;
    localparam int unsigned VLDB_LSB = 32;
    localparam int unsigned VLDB_MSB = 33;
    localparam int unsigned LAST_BIT = 34;

    // vldb encodes valid bytes minus one; 3 means all four bytes valid
    localparam logic [VLDB_W-1:0] VLDB_FULL = 2'd3;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t ST_IDLE    = 2'd0;
    localparam wr_state_t ST_WR      = 2'd1;
    localparam wr_state_t ST_DISCARD = 2'd2;

    typedef struct packed {
        logic              last;
        logic [VLDB_W-1:0] vldb;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    // Non-last beats are always full width, so their vldb is normalised.
    function automatic fifo_word_t make_word(input logic              last,
                                             input logic [VLDB_W-1:0] vldb,
                                             input logic [DATA_W-1:0] data);
        fifo_word_t w;
        w.last = last;
        w.vldb = last ? vldb : VLDB_FULL;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, single clock, one write port and one registered read port.
// The read register clears on reset and holds its value while re is low.
module sdp_ram #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward buffer behind one MAC receive lane: absorbs whole frames,
// drops bad/overflowing/link-cut frames and replays good frames with backpressure.
module rx_frame_fifo
    import rx_frame_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              link_up_i,
    input  logic [31:0]       s_tdata_i,
    input  logic [1:0]        s_tvldb_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    input  logic              s_tuser_i,
    output logic [31:0]       m_tdata_o,
    output logic [1:0]        m_tvldb_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [CNT_W-1:0]  good_cnt_o,
    output logic [ADDR_W:0]   level_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wr_state_t        state;
    wr_state_t        nxt_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             avail;
    logic             load;
    logic             wr_en_c;
    logic             commit_c;
    logic             drop_c;
    fifo_word_t       wr_word;
    logic [WORD_W-1:0] ram_q;

    // Uses registered pointers only, so a read this cycle frees space next cycle.
    assign full    = (wr_ptr - rd_ptr) == DEPTH_P;
    assign avail   = rd_ptr != commit_ptr;
    assign load    = avail && (!m_tvalid_o || m_tready_i);
    assign wr_word = make_word(s_tlast_i, s_tvldb_i, s_tdata_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Write-side frame FSM: decides per beat whether to write, commit or drop.
    always_comb begin
        nxt_state = state;
        wr_en_c   = 1'b0;
        commit_c  = 1'b0;
        drop_c    = 1'b0;
        case (state)
            ST_IDLE, ST_WR: begin
                if (!link_up_i) begin
                    if (state == ST_WR) begin
                        drop_c    = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end else if (s_tvalid_i) begin
                    if (s_tlast_i && s_tuser_i) begin
                        drop_c    = 1'b1;
                        nxt_state = ST_IDLE;
                    end else if (full) begin
                        if (s_tlast_i) begin
                            drop_c    = 1'b1;
                            nxt_state = ST_IDLE;
                        end else begin
                            nxt_state = ST_DISCARD;
                        end
                    end else begin
                        wr_en_c = 1'b1;
                        if (s_tlast_i) begin
                            commit_c  = 1'b1;
                            nxt_state = ST_IDLE;
                        end else begin
                            nxt_state = ST_WR;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (!link_up_i || (s_tvalid_i && s_tlast_i)) begin
                    drop_c    = 1'b1;
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // A drop rewinds the write pointer to the last committed frame boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (drop_c) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (commit_c) begin
                commit_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_tvalid_o <= 1'b0;
        end else if (load) begin
            m_tvalid_o <= 1'b1;
        end else if (m_tready_i) begin
            m_tvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
            good_cnt_o <= '0;
            level_o    <= '0;
        end else begin
            if (drop_c && (drop_cnt_o != CNT_MAX)) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
            if (commit_c && (good_cnt_o != CNT_MAX)) begin
                good_cnt_o <= good_cnt_o + CNT_W'(1);
            end
            level_o <= commit_ptr - rd_ptr;
        end
    end

    // The RAM read register doubles as the output register.
    sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (wr_en_c),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_word),
        .re    (load),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    assign m_tdata_o = ram_q[DATA_MSB:DATA_LSB];
    assign m_tvldb_o = ram_q[VLDB_MSB:VLDB_LSB];
    assign m_tlast_o = ram_q[LAST_BIT];

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo: per-scenario tasks with hand-computed expectations.
// A background process drives m_tready_i and records every accepted output beat.
module tb_rx_frame_fifo;

    typedef struct packed {
        logic        last;
        logic [1:0]  vldb;
        logic [31:0] data;
    } beat_t;

    logic        clk_i;
    logic        rst_i;
    logic        link_up_i;
    logic [31:0] s_tdata_i;
    logic [1:0]  s_tvldb_i;
    logic        s_tvalid_i;
    logic        s_tlast_i;
    logic        s_tuser_i;
    logic [31:0] m_tdata_o;
    logic [1:0]  m_tvldb_o;
    logic        m_tvalid_o;
    logic        m_tready_i;
    logic        m_tlast_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] good_cnt_o;
    logic [9:0]  level_o;

    int    checks;
    int    errors;
    int    ready_mode;
    int    stall_viol;
    beat_t out_q[$];
    beat_t exp_q[$];

    rx_frame_fifo #(.ADDR_W(9), .CNT_W(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .link_up_i  (link_up_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvldb_i  (s_tvldb_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .s_tuser_i  (s_tuser_i),
        .m_tdata_o  (m_tdata_o),
        .m_tvldb_o  (m_tvldb_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o),
        .drop_cnt_o (drop_cnt_o),
        .good_cnt_o (good_cnt_o),
        .level_o    (level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Output sink: 0 = never ready, 1 = always ready, 2 = random ready.
    initial begin
        beat_t prev;
        bit    prev_stalled;
        prev_stalled = 1'b0;
        prev         = '0;
        m_tready_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (prev_stalled && (m_tvalid_o !== 1'b1 || m_tdata_o !== prev.data ||
                                 m_tvldb_o !== prev.vldb || m_tlast_o !== prev.last)) begin
                stall_viol++;
            end
            if (ready_mode == 2) m_tready_i = 1'($urandom_range(1, 0));
            else                 m_tready_i = (ready_mode == 1);
            if (m_tvalid_o === 1'b1 && m_tready_i) begin
                out_q.push_back({m_tlast_o, m_tvldb_o, m_tdata_o});
            end
            prev_stalled = (m_tvalid_o === 1'b1) && !m_tready_i;
            prev         = {m_tlast_o, m_tvldb_o, m_tdata_o};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i      = 1'b1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
        s_tdata_i  = '0;
        s_tvldb_i  = '0;
        link_up_i  = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;
        step();
        out_q.delete();
        stall_viol = 0;
    endtask

    task automatic send_frame(input int len, input logic [31:0] base, input logic [31:0] inc,
                              input logic [1:0] vldb, input logic user);
        for (int i = 0; i < len; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = base + inc * 32'(i);
            s_tlast_i  = (i == len - 1);
            s_tvldb_i  = vldb;
            s_tuser_i  = user && (i == len - 1);
            step();
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
    endtask

    task automatic test_reset();
        ready_mode = 1;
        apply_reset();
        checks += 7;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid_o); end
        if (m_tdata_o !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata_o); end
        if (m_tvldb_o !== 2'h0) begin errors++; $display("FAIL reset_tvldb: got %0h expected 0", m_tvldb_o); end
        if (m_tlast_o !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b expected 0", m_tlast_o); end
        if (drop_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
        if (good_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_good: got %0d expected 0", good_cnt_o); end
        if (level_o !== 10'h0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    endtask

    task automatic test_single_frame();
        ready_mode = 1;
        apply_reset();
        send_frame(4, 32'h11111111, 32'h11111111, 2'd2, 1'b0);
        checks++;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL single_lat_n1: tvalid got %0b expected 0", m_tvalid_o); end
        step();
        checks += 2;
        if (m_tvalid_o !== 1'b1) begin errors++; $display("FAIL single_lat_n2: tvalid got %0b expected 1", m_tvalid_o); end
        if (m_tdata_o !== 32'h11111111) begin errors++; $display("FAIL single_first: got %0h expected 11111111", m_tdata_o); end
        for (int c = 0; c < 20 && out_q.size() < 4; c++) step();
        repeat (4) step();
        checks++;
        if (out_q.size() != 4) begin
            errors++; $display("FAIL single_count: got %0d beats expected 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (out_q[i].data !== 32'(32'h11111111 * 32'(i + 1))) begin
                    errors++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, out_q[i].data, 32'(32'h11111111 * 32'(i + 1)));
                end
                if (out_q[i].last !== (i == 3)) begin
                    errors++; $display("FAIL single_last[%0d]: got %0b expected %0b", i, out_q[i].last, (i == 3));
                end
            end
            checks++;
            if (out_q[3].vldb !== 2'd2) begin errors++; $display("FAIL single_vldb: got %0d expected 2", out_q[3].vldb); end
        end
        checks += 3;
        if (good_cnt_o !== 16'd1) begin errors++; $display("FAIL single_good: got %0d expected 1", good_cnt_o); end
        if (level_o !== 10'd0) begin errors++; $display("FAIL single_level: got %0d expected 0", level_o); end
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL single_idle: tvalid got %0b expected 0", m_tvalid_o); end
    endtask

    task automatic test_bad_frame();
        ready_mode = 1;
        apply_reset();
        send_frame(3, 32'hBAD00000, 32'h1, 2'd3, 1'b1);
        send_frame(2, 32'h22220000, 32'h1, 2'd1, 1'b0);
        for (int c = 0; c < 20 && out_q.size() < 2; c++) step();
        repeat (4) step();
        checks += 3;
        if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL bad_drop: got %0d expected 1", drop_cnt_o); end
        if (good_cnt_o !== 16'd1) begin errors++; $display("FAIL bad_good: got %0d expected 1", good_cnt_o); end
        if (out_q.size() != 2) begin
            errors++; $display("FAIL bad_count: got %0d beats expected 2", out_q.size());
        end else begin
            checks += 3;
            if (out_q[0].data !== 32'h22220000) begin errors++; $display("FAIL bad_data0: got %0h expected 22220000", out_q[0].data); end
            if (out_q[1].data !== 32'h22220001) begin errors++; $display("FAIL bad_data1: got %0h expected 22220001", out_q[1].data); end
            if (out_q[1].last !== 1'b1 || out_q[1].vldb !== 2'd1) begin
                errors++; $display("FAIL bad_tail: got last %0b vldb %0d expected last 1 vldb 1", out_q[1].last, out_q[1].vldb);
            end
        end
    endtask

    task automatic test_overflow();
        int lasts;
        ready_mode = 0;
        apply_reset();
        send_frame(600, 32'h0, 32'h1, 2'd3, 1'b0);
        repeat (3) step();
        checks += 3;
        if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_drop1: got %0d expected 1", drop_cnt_o); end
        if (level_o !== 10'd0) begin errors++; $display("FAIL ovf_level0: got %0d expected 0", level_o); end
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL ovf_novalid: got %0b expected 0", m_tvalid_o); end
        send_frame(512, 32'h1000, 32'h1, 2'd3, 1'b0);
        send_frame(1, 32'hDEAD0000, 32'h1, 2'd0, 1'b0);
        checks += 3;
        if (level_o !== 10'd512) begin errors++; $display("FAIL ovf_level512: got %0d expected 512", level_o); end
        if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_drop2: got %0d expected 2", drop_cnt_o); end
        if (good_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_good: got %0d expected 1", good_cnt_o); end
        repeat (2) step();
        checks += 3;
        if (level_o !== 10'd511) begin errors++; $display("FAIL ovf_level511: got %0d expected 511", level_o); end
        if (m_tvalid_o !== 1'b1) begin errors++; $display("FAIL ovf_held_valid: got %0b expected 1", m_tvalid_o); end
        if (m_tdata_o !== 32'h1000) begin errors++; $display("FAIL ovf_held_data: got %0h expected 1000", m_tdata_o); end
        ready_mode = 1;
        for (int c = 0; c < 1200 && out_q.size() < 512; c++) step();
        repeat (4) step();
        checks++;
        if (out_q.size() != 512) begin
            errors++; $display("FAIL ovf_count: got %0d beats expected 512", out_q.size());
        end else begin
            lasts = 0;
            for (int i = 0; i < 512; i++) begin
                checks++;
                if (out_q[i].data !== 32'h1000 + 32'(i)) begin
                    errors++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, out_q[i].data, 32'h1000 + 32'(i));
                end
                if (out_q[i].last === 1'b1) lasts++;
            end
            checks += 2;
            if (lasts != 1) begin errors++; $display("FAIL ovf_lasts: got %0d expected 1", lasts); end
            if (out_q[511].last !== 1'b1) begin errors++; $display("FAIL ovf_last511: got %0b expected 1", out_q[511].last); end
        end
        checks += 2;
        if (level_o !== 10'd0) begin errors++; $display("FAIL ovf_drained: level got %0d expected 0", level_o); end
        if (stall_viol != 0) begin errors++; $display("FAIL ovf_stable: got %0d stall changes expected 0", stall_viol); end
    endtask

    task automatic test_link_loss();
        ready_mode = 1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            link_up_i  = (i < 4);
            s_tvalid_i = 1'b1;
            s_tdata_i  = 32'hC0DE0000 + 32'(i);
            s_tlast_i  = (i == 9);
            s_tvldb_i  = 2'd3;
            s_tuser_i  = 1'b0;
            step();
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        link_up_i  = 1'b1;
        repeat (4) step();
        checks += 3;
        if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL link_drop: got %0d expected 1", drop_cnt_o); end
        if (good_cnt_o !== 16'd0) begin errors++; $display("FAIL link_good0: got %0d expected 0", good_cnt_o); end
        if (out_q.size() != 0) begin errors++; $display("FAIL link_noout: got %0d beats expected 0", out_q.size()); end
        send_frame(3, 32'h77770000, 32'h1, 2'd1, 1'b0);
        for (int c = 0; c < 20 && out_q.size() < 3; c++) step();
        repeat (4) step();
        checks += 2;
        if (good_cnt_o !== 16'd1) begin errors++; $display("FAIL link_good1: got %0d expected 1", good_cnt_o); end
        if (out_q.size() != 3) begin
            errors++; $display("FAIL link_count: got %0d beats expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (out_q[i].data !== 32'h77770000 + 32'(i)) begin
                    errors++; $display("FAIL link_data[%0d]: got %0h expected %0h", i, out_q[i].data, 32'h77770000 + 32'(i));
                end
                if (out_q[i].last !== (i == 2)) begin
                    errors++; $display("FAIL link_last[%0d]: got %0b expected %0b", i, out_q[i].last, (i == 2));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lens [3];
        logic [1:0] vl [3];
        lens = '{1, 7, 64};
        vl   = '{2'd0, 2'd1, 2'd3};
        ready_mode = 2;
        apply_reset();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < lens[f]; i++) begin
                exp_q.push_back({(i == lens[f] - 1), vl[f], (32'(f + 1) << 24) + 32'(i)});
            end
        end
        for (int f = 0; f < 3; f++) begin
            send_frame(lens[f], 32'(f + 1) << 24, 32'h1, vl[f], 1'b0);
        end
        for (int c = 0; c < 800 && out_q.size() < exp_q.size(); c++) step();
        ready_mode = 1;
        repeat (4) step();
        checks += 3;
        if (good_cnt_o !== 16'd3) begin errors++; $display("FAIL b2b_good: got %0d expected 3", good_cnt_o); end
        if (stall_viol != 0) begin errors++; $display("FAIL b2b_stable: got %0d stall changes expected 0", stall_viol); end
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d beats expected %0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks += 2;
                if (out_q[i].data !== exp_q[i].data) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, out_q[i].data, exp_q[i].data);
                end
                if (out_q[i].last !== exp_q[i].last) begin
                    errors++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", i, out_q[i].last, exp_q[i].last);
                end
                if (exp_q[i].last) begin
                    checks++;
                    if (out_q[i].vldb !== exp_q[i].vldb) begin
                        errors++; $display("FAIL b2b_vldb[%0d]: got %0d expected %0d", i, out_q[i].vldb, exp_q[i].vldb);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        ready_mode = 0;
        apply_reset();
        send_frame(2, 32'hAAAA0000, 32'h1, 2'd3, 1'b0);
        repeat (3) step();
        checks += 2;
        if (good_cnt_o !== 16'd1) begin errors++; $display("FAIL mrst_pre_good: got %0d expected 1", good_cnt_o); end
        if (m_tvalid_o !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %0b expected 1", m_tvalid_o); end
        for (int i = 0; i < 2; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = 32'hBBBB0000 + 32'(i);
            s_tlast_i  = 1'b0;
            s_tvldb_i  = 2'd3;
            step();
        end
        rst_i      = 1'b1;
        s_tvalid_i = 1'b0;
        #1;
        checks += 5;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %0b expected 0", m_tvalid_o); end
        if (m_tdata_o !== 32'h0) begin errors++; $display("FAIL mrst_data: got %0h expected 0", m_tdata_o); end
        if (m_tlast_o !== 1'b0 || m_tvldb_o !== 2'd0) begin
            errors++; $display("FAIL mrst_flags: got last %0b vldb %0d expected 0 0", m_tlast_o, m_tvldb_o);
        end
        if (good_cnt_o !== 16'd0) begin errors++; $display("FAIL mrst_good: got %0d expected 0", good_cnt_o); end
        if (level_o !== 10'd0) begin errors++; $display("FAIL mrst_level: got %0d expected 0", level_o); end
        repeat (2) step();
        rst_i = 1'b0;
        step();
        out_q.delete();
        ready_mode = 1;
        send_frame(2, 32'h55550000, 32'h1, 2'd0, 1'b0);
        for (int c = 0; c < 20 && out_q.size() < 2; c++) step();
        repeat (6) step();
        checks++;
        if (out_q.size() != 2) begin
            errors++; $display("FAIL mrst_count: got %0d beats expected 2", out_q.size());
        end else begin
            checks += 2;
            if (out_q[0].data !== 32'h55550000) begin errors++; $display("FAIL mrst_data0: got %0h expected 55550000", out_q[0].data); end
            if (out_q[1].data !== 32'h55550001 || out_q[1].last !== 1'b1) begin
                errors++; $display("FAIL mrst_data1: got %0h last %0b expected 55550001 last 1", out_q[1].data, out_q[1].last);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stall_viol = 0;
        ready_mode = 0;
        rst_i      = 1'b1;
        link_up_i  = 1'b1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
        s_tdata_i  = '0;
        s_tvldb_i  = '0;
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_overflow();
        test_link_loss();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
